score_pulse_tx: RTL and testbench



---
 rtl/game_pkg.sv | 19 +
 rtl/pulse_timer.sv | 27 ++
 rtl/score_pulse_tx.sv | 93 +++++++++
 tb/tb_score_pulse_tx.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared types and sizing for the score pulse transmitter.
package game_pkg;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_GAP  = 2'd2
    } state_e;

    localparam int SCORE_W    = 4;
    localparam int PEND_W     = 6;
    localparam int PEND_LIMIT = (1 << PEND_W) - 1 - ((1 << SCORE_W) - 1);

    // Width needed to hold the larger reload value (phase length minus one).
    function automatic int tmr_w(input int hi, input int gap);
        int m;
        m = (hi > gap) ? hi : gap;
        return (m > 1) ? $clog2(m) : 1;
    endfunction
endpackage

// File: rtl/pulse_timer.sv
// Loadable down-counter; done_o is high once the count has reached zero.
module pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] val_i,
    output logic         done_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = val_i;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign done_o = (cnt_q == '0);
endmodule

// File: rtl/score_pulse_tx.sv
// Accumulates score awards and replays them as fixed-width pulses, one per point.
module score_pulse_tx
    import game_pkg::*;
#(
    parameter int PULSE_HI  = 2,
    parameter int PULSE_GAP = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [SCORE_W-1:0] get_score,
    input  logic               score_valid,
    output logic               score_ready,
    input  logic               game_end,
    output logic               score_signal,
    output logic [PEND_W-1:0]  pending,
    output logic               busy
);
    localparam int TW = tmr_w(PULSE_HI, PULSE_GAP);
    localparam logic [TW-1:0] HI_LD  = TW'(PULSE_HI - 1);
    localparam logic [TW-1:0] GAP_LD = TW'(PULSE_GAP - 1);

    state_e             state_q, state_d;
    logic               sig_q, sig_d;
    logic [PEND_W-1:0]  pend_q, pend_d;
    logic               ld, done, start, can_start, accept;
    logic [TW-1:0]      ld_val;

    assign score_ready = !game_end && (pend_q <= PEND_W'(PEND_LIMIT));
    assign accept      = score_valid && score_ready;
    assign can_start   = (pend_q != '0) && !game_end;

    pulse_timer #(.W(TW)) u_tmr (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (ld),
        .val_i  (ld_val),
        .done_o (done)
    );

    always_comb begin
        state_d = state_q;
        sig_d   = sig_q;
        ld      = 1'b0;
        ld_val  = '0;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: if (can_start) begin
                start = 1'b1;
            end
            ST_HIGH: if (done) begin
                state_d = ST_GAP;
                sig_d   = 1'b0;
                ld      = 1'b1;
                ld_val  = GAP_LD;
            end
            ST_GAP: if (done) begin
                // Chain straight into the next pulse so the period never stretches.
                if (can_start) start = 1'b1;
                else           state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (start) begin
            state_d = ST_HIGH;
            sig_d   = 1'b1;
            ld      = 1'b1;
            ld_val  = HI_LD;
        end
    end

    always_comb begin
        if (game_end)
            pend_d = '0;
        else
            pend_d = pend_q + (accept ? PEND_W'(get_score) : '0) - PEND_W'(start);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            sig_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            sig_q   <= sig_d;
            pend_q  <= pend_d;
        end
    end

    assign score_signal = sig_q;
    assign pending      = pend_q;
    assign busy         = (state_q != ST_IDLE) || (pend_q != '0);
endmodule

// File: tb/tb_score_pulse_tx.sv
// Drives two transmitter configurations (2/2 and 1/1) and compares every cycle to a period-based model.
module tb_score_pulse_tx;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] get_score = '0;
    logic       score_valid = 1'b0;
    logic       game_end = 1'b0;
    logic       rdy[2], sig[2], bsy[2];
    logic [5:0] pnd[2];

    always #5 clk = ~clk;

    score_pulse_tx u0 (
        .clk(clk), .rst_n(rst_n), .get_score(get_score), .score_valid(score_valid),
        .score_ready(rdy[0]), .game_end(game_end), .score_signal(sig[0]),
        .pending(pnd[0]), .busy(bsy[0])
    );
    score_pulse_tx #(.PULSE_HI(1), .PULSE_GAP(1)) u1 (
        .clk(clk), .rst_n(rst_n), .get_score(get_score), .score_valid(score_valid),
        .score_ready(rdy[1]), .game_end(game_end), .score_signal(sig[1]),
        .pending(pnd[1]), .busy(bsy[1])
    );

    int n_cmp = 0;
    int n_bad = 0;
    int rises0 = 0;
    int m_pend[2];
    int m_t[2];   // cycles left in the current pulse period, 0 when idle
    int m_hi[2]  = '{2, 1};
    int m_gap[2] = '{2, 1};

    always @(posedge sig[0]) rises0++;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_pend[i] = 0;
            m_t[i]    = 0;
        end
    endfunction

    function automatic void model_edge();
        for (int i = 0; i < 2; i++) begin
            bit rd, acc, st;
            rd  = !game_end && m_pend[i] <= 48;
            acc = score_valid && rd;
            st  = (m_t[i] <= 1) && m_pend[i] != 0 && !game_end;
            if (game_end) m_pend[i] = 0;
            else          m_pend[i] = m_pend[i] + (acc ? int'(get_score) : 0) - (st ? 1 : 0);
            if (st)            m_t[i] = m_hi[i] + m_gap[i];
            else if (m_t[i] > 0) m_t[i] = m_t[i] - 1;
        end
    endfunction

    task automatic check_all();
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("sig%0d", i),  int'(sig[i]), int'(m_t[i] > m_gap[i]));
            chk($sformatf("pend%0d", i), int'(pnd[i]), m_pend[i]);
            chk($sformatf("busy%0d", i), int'(bsy[i]), int'(m_t[i] > 0 || m_pend[i] != 0));
            chk($sformatf("rdy%0d", i),  int'(rdy[i]), int'(!game_end && m_pend[i] <= 48));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic award(input int pts);
        score_valid = 1'b1;
        get_score   = 4'(pts);
        tick();
        score_valid = 1'b0;
    endtask

    initial begin
        model_reset();
        #2;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // three points from idle
        rises0 = 0;
        award(3);
        repeat (16) tick();
        chk("s1_rises", rises0, 3);

        // back-to-back 15s up to the ready threshold
        score_valid = 1'b1;
        get_score   = 4'd15;
        repeat (5) tick();
        score_valid = 1'b0;
        repeat (260) tick();

        // award during GAP of the last pulse
        award(1);
        repeat (3) tick();
        award(2);
        repeat (12) tick();

        // game_end one cycle into a HIGH with pending 5
        rises0 = 0;
        award(6);
        tick();
        game_end = 1'b1;
        repeat (8) tick();
        game_end = 1'b0;
        repeat (4) tick();
        chk("s4_rises", rises0, 1);

        // asynchronous reset mid-HIGH
        award(5);
        tick();
        @(posedge clk);
        model_edge();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_sig", int'(sig[0]), 0);
        chk("arst_pend", int'(pnd[0]), 0);
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
        rises0 = 0;
        award(1);
        repeat (8) tick();
        chk("s5_rises", rises0, 1);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            score_valid = ($urandom % 3) == 0;
            get_score   = 4'($urandom % 16);
            if (($urandom % 40) == 0) game_end = ~game_end;
            tick();
        end
        score_valid = 1'b0;
        game_end    = 1'b0;
        repeat (300) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
